// File: rtl/window_gen_3x3.sv
// window_gen_3x3: streaming 3x3 sliding-window generator feeding the 9-tap MAC.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_sof/in_pixel raster pixel input;
//        out_valid/out_ready window handshake; px0..px8 window (row-major, px8 newest); out_x/out_y centre; out_last.
// Latency: window visible the cycle after its px8 pixel is accepted; in_ready drops while a window is stalled.
module window_gen_3x3 #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] px0,
  output logic [PIX_W-1:0] px1,
  output logic [PIX_W-1:0] px2,
  output logic [PIX_W-1:0] px3,
  output logic [PIX_W-1:0] px4,
  output logic [PIX_W-1:0] px5,
  output logic [PIX_W-1:0] px6,
  output logic [PIX_W-1:0] px7,
  output logic [PIX_W-1:0] px8,
  output logic [XW-1:0]    out_x,
  output logic [YW-1:0]    out_y,
  output logic             out_last
);

  // Line memories: lb0 holds the previous row, lb1 the row before that.
  // Not reset: a location is always rewritten before it can reach a valid window.
  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];

  logic [XW-1:0]    x_cnt;
  logic [YW-1:0]    y_cnt;
  logic [XW-1:0]    cx;
  logic [YW-1:0]    cy;
  logic             accept;
  logic             x_end;
  logic             y_end;
  logic [PIX_W-1:0] top;
  logic [PIX_W-1:0] mid;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Start-of-frame forces the current pixel to (0,0) regardless of the counters.
  assign cx    = in_sof ? '0 : x_cnt;
  assign cy    = in_sof ? '0 : y_cnt;
  assign x_end = (cx == XW'(IMG_W - 1));
  assign y_end = (cy == YW'(IMG_H - 1));

  // Read happens in the same cycle as the write below (read-before-write).
  assign top = lb1[cx];
  assign mid = lb0[cx];

  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      lb1[cx] <= mid;
      lb0[cx] <= in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      px0 <= '0; px1 <= '0; px2 <= '0;
      px3 <= '0; px4 <= '0; px5 <= '0;
      px6 <= '0; px7 <= '0; px8 <= '0;
    end else if (accept) begin
      px0 <= px1; px1 <= px2; px2 <= top;
      px3 <= px4; px4 <= px5; px5 <= mid;
      px6 <= px7; px7 <= px8; px8 <= in_pixel;

      if (x_end) begin
        x_cnt <= '0;
        y_cnt <= y_end ? '0 : cy + YW'(1);
      end else begin
        x_cnt <= cx + XW'(1);
        y_cnt <= cy;
      end

      // Only fully interior neighbourhoods are emitted; the first two rows and
      // columns would otherwise expose stale line-memory data.
      out_valid <= (cx >= XW'(2)) && (cy >= YW'(2));
      out_x     <= cx - XW'(1);
      out_y     <= cy - YW'(1);
      out_last  <= x_end && y_end;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
